// File: rtl/alsu_result_tx.sv
// alsu_result_tx: buffers ALSU result words in a small FIFO and sends each one
// as a 10-bit UART-style frame: start, d[0..5], err, even parity, stop.
module alsu_result_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          res_valid,
  input  logic [5:0]                    res_data,
  input  logic                          res_err,
  input  logic                          ovf_clr,
  output logic                          res_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   FULL      = CW'(FIFO_DEPTH);
  localparam logic [7:0]      BAUD_LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    ERR,
    PARITY,
    STOP
  } state_t;

  // FIFO storage and pointers
  logic [6:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [6:0]    head;
  logic          push;
  logic          pop;

  // Serialiser state
  state_t        state, state_d;
  logic [7:0]    shift, shift_d;     // {parity, err, d[5:0]}, shifted out LSB first
  logic [7:0]    baud, baud_d;
  logic [2:0]    bit_cnt, bit_d;
  logic          tx_d;
  logic          tick;

  assign res_ready = (fifo_count != FULL);
  assign push      = res_valid && res_ready;
  assign head      = mem[rd_ptr];
  assign tick      = (baud == BAUD_LAST);
  assign busy      = (state != IDLE);

  // Payload storage: written on accepted pushes only
  // NOTE: the data array has no reset; occupancy is tracked by the pointers and
  // count, so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {res_err, res_data};
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth
  // NOTE: sequential state is always assigned with <= so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky overflow: a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (res_valid && !res_ready) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // Serialiser registers; tx is registered from the next-state decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      baud    <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      baud    <= baud_d;
      bit_cnt <= bit_d;
      tx      <= tx_d;
    end
  end

  // Next-state, pop and line-level decode
  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    shift_d = shift;
    bit_d   = bit_cnt;
    baud_d  = tick ? 8'd0 : baud + 8'd1;
    pop     = 1'b0;

    unique case (state)
      IDLE: begin
        baud_d = '0;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_d = {^head, head};
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift >> 1;
          if (bit_cnt == 3'd5) begin
            bit_d   = '0;
            state_d = ERR;
          end else begin
            bit_d = bit_cnt + 3'd1;
          end
        end
      end
      ERR: begin
        if (tick) begin
          shift_d = shift >> 1;
          state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick) begin
          if (fifo_count != '0) begin
            pop     = 1'b1;
            shift_d = {^head, head};
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:             tx_d = 1'b0;
      DATA, ERR, PARITY: tx_d = shift_d[0];
      default:           tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_alsu_result_tx.sv
// tb_alsu_result_tx: directed and randomized stimulus into two instances
// (CLKS_PER_BIT=4/FIFO_DEPTH=4 and CLKS_PER_BIT=1/FIFO_DEPTH=2), compared every
// cycle against a frame-countdown reference model.
module tb_alsu_result_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic [5:0] res_data;
  logic       res_err;
  logic       ovf_clr;

  logic       ready0, tx0, busy0, ovf0;
  logic [2:0] cnt0;
  logic       ready1, tx1, busy1, ovf1;
  logic [1:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  alsu_result_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .res_err(res_err), .ovf_clr(ovf_clr), .res_ready(ready0), .tx(tx0),
    .busy(busy0), .overflow(ovf0), .fifo_count(cnt0)
  );

  alsu_result_tx #(.CLKS_PER_BIT(1), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .res_err(res_err), .ovf_clr(ovf_clr), .res_ready(ready1), .tx(tx1),
    .busy(busy1), .overflow(ovf1), .fifo_count(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance: a queue of waiting words plus the frame currently on the
  // line, described as 10 bits and a count of remaining line cycles.
  int         cpb   [2] = '{4, 1};
  int         depth [2] = '{4, 2};
  logic [6:0] qmem  [2][16];
  int         qhead [2];
  int         qsize [2];
  int         left  [2];
  logic [9:0] frame [2];
  bit         movf  [2];
  int         m_sz, m_tail;
  bit         m_room;
  logic [6:0] m_w;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        qhead[i] = 0; qsize[i] = 0; left[i] = 0; movf[i] = 1'b0; frame[i] = '1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_sz   = qsize[i];
        m_room = (m_sz != depth[i]);
        m_tail = (qhead[i] + m_sz) % 16;
        if (left[i] > 1) begin
          left[i]--;
        end else if (m_sz != 0) begin
          m_w      = qmem[i][qhead[i]];
          qhead[i] = (qhead[i] + 1) % 16;
          qsize[i]--;
          frame[i] = {1'b1, ^m_w, m_w, 1'b0};
          left[i]  = 10 * cpb[i];
        end else begin
          left[i] = 0;
        end
        if (res_valid && m_room) begin
          qmem[i][m_tail] = {res_err, res_data};
          qsize[i]++;
        end
        if (res_valid && !m_room) movf[i] = 1'b1;
        else if (ovf_clr)         movf[i] = 1'b0;
      end
    end
  end

  function automatic logic exp_tx(input int i);
    if (left[i] == 0) return 1'b1;
    return frame[i][(10 * cpb[i] - left[i]) / cpb[i]];
  endfunction

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("tx0",    32'(tx0),    32'(exp_tx(0)));
      check("busy0",  32'(busy0),  32'(left[0] != 0));
      check("cnt0",   32'(cnt0),   32'(qsize[0]));
      check("ready0", 32'(ready0), 32'(qsize[0] != depth[0]));
      check("ovf0",   32'(ovf0),   32'(movf[0]));
      check("tx1",    32'(tx1),    32'(exp_tx(1)));
      check("busy1",  32'(busy1),  32'(left[1] != 0));
      check("cnt1",   32'(cnt1),   32'(qsize[1]));
      check("ready1", 32'(ready1), 32'(qsize[1] != depth[1]));
      check("ovf1",   32'(ovf1),   32'(movf[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drain();
    int n;
    n = 0;
    res_valid = 1'b0;
    ovf_clr   = 1'b0;
    while ((busy0 || busy1 || cnt0 != 0 || cnt1 != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", 32'(n < 3000), 32'd1);
    @(negedge clk);
  endtask

  // Push one word from idle and capture the tx level mid-way through each bit
  task automatic send_one(input logic [5:0] d, input logic e, output logic [9:0] seen);
    res_data  = d;
    res_err   = e;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    seen = '0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 1) seen[b] = tx0;
        check("frame_busy", 32'(busy0), 32'd1);
      end
    end
    @(negedge clk);
    check("post_frame_tx", 32'(tx0), 32'd1);
    check("post_frame_busy", 32'(busy0), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] seen;
    int rate;

    rst = 1'b0; res_valid = 1'b0; res_data = '0; res_err = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_tx",    32'(tx0),    32'd1);
    check("rst_busy",  32'(busy0),  32'd0);
    check("rst_ready", 32'(ready0), 32'd1);
    check("rst_ovf",   32'(ovf0),   32'd0);
    check("rst_cnt",   32'(cnt0),   32'd0);
    @(negedge clk);
    rst    = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Single frame and payload/parity slots
    send_one(6'b101101, 1'b0, seen);
    check("frame_101101", 32'(seen), 32'(10'b1001011010));
    send_one(6'b000001, 1'b1, seen);
    check("err_slot", 32'(seen[7]), 32'd1);
    check("par_slot_err", 32'(seen[8]), 32'd0);
    send_one(6'b000011, 1'b0, seen);
    check("par_000011", 32'(seen[8]), 32'd0);
    send_one(6'b000111, 1'b0, seen);
    check("par_000111", 32'(seen[8]), 32'd1);
    drain();

    // Fill and overflow: six consecutive offers A..F
    for (int k = 0; k < 6; k++) begin
      res_data  = 6'(10 + k);
      res_err   = (k % 2 == 1);
      res_valid = 1'b1;
      @(negedge clk);
      if (k == 4) begin
        check("fill_cnt",   32'(cnt0),   32'd4);
        check("fill_ready", 32'(ready0), 32'd0);
      end
    end
    check("fill_ovf", 32'(ovf0), 32'd1);
    check("fill_cnt_after_drop", 32'(cnt0), 32'd4);

    // Overflow clear alone, then clear colliding with a drop
    res_valid = 1'b0;
    ovf_clr   = 1'b1;
    @(negedge clk);
    check("ovf_clr_alone", 32'(ovf0), 32'd0);
    res_valid = 1'b1;
    @(negedge clk);
    check("ovf_set_wins", 32'(ovf0), 32'd1);
    ovf_clr   = 1'b0;
    res_valid = 1'b0;
    drain();

    // Reset in the middle of a frame, with words still buffered
    for (int k = 0; k < 3; k++) begin
      res_data  = 6'(k * 7 + 5);
      res_err   = 1'b0;
      res_valid = 1'b1;
      @(negedge clk);
    end
    res_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx",   32'(tx0),   32'd1);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_cnt",  32'(cnt0),  32'd0);
    check("midrst_tx1",  32'(tx1),   32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    res_data  = 6'b110010;
    res_err   = 1'b1;
    res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    check("restart_idle_before", 32'(busy0), 32'd0);
    @(negedge clk);
    check("restart_busy", 32'(busy0), 32'd1);
    check("restart_start", 32'(tx0), 32'd0);
    drain();

    // Randomized traffic with varying offer rates and occasional clears
    rate = 40;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) rate = $urandom_range(5, 95);
      res_valid = ($urandom_range(0, 99) < rate);
      res_data  = 6'($urandom);
      res_err   = 1'($urandom);
      ovf_clr   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
